spi_regfile_peripheral: RTL and testbench
=========================================

# spi_regfile_peripheral

Parametrised SPI (mode 0, MSB first) target with a generic register bank: the successor to the fixed five-register write-only peripheral. Sits between the chip's SPI pins and the output/PWM control logic. Adds configurable address/data width and register count, read-back on CIPO, commit-on-nCS-rise, and framing-error reporting. All SPI pins are oversampled in the `clk` domain.

## Interface
- `ADDR_W`, 7, address field width; frame is `FRAME_W = 1 + ADDR_W + DATA_W` bits
- `DATA_W`, 8, register width
- `NUM_REGS`, 5, implemented registers (addresses 0..NUM_REGS-1), 1..2^ADDR_W
- `SYNC_STAGES`, 2, synchroniser depth on SCLK/nCS/COPI, ≥2
- `clk  in  1` system clock; single clock domain
- `rst_n  in  1` reset, synchronous and active-low
- `SCLK  in  1` SPI clock, asynchronous
- `nCS  in  1` chip select, active-low, asynchronous
- `COPI  in  1` controller-out data, asynchronous
- `CIPO  out  1` peripheral-out data, MSB first
- `cipo_oe  out  1` high while a read data phase is active
- `regs_flat  out  NUM_REGS*DATA_W` register bank, reg k at `[k*DATA_W +: DATA_W]`
- `wr_strobe  out  1` one-cycle pulse on every committed write
- `wr_addr  out  ADDR_W` address of last committed write
- `frame_err  out  1` one-cycle pulse on every discarded frame

## Operation
- Frame: bit 1 = R/W (1 write, 0 read), then ADDR_W address bits, then DATA_W data bits.
- Bits sampled on synchronised SCLK rise while synchronised nCS low; SCLK ignored when nCS high.
- FSM `IDLE → HDR → DATA → DONE`:
  - IDLE: nCS fall → HDR, bit count 0.
  - HDR: shift R/W+address; after bit 1+ADDR_W → DATA. If read: load addressed register (0 if address ≥ NUM_REGS) into TX shifter, assert `cipo_oe`.
  - DATA: write shifts COPI into RX; read shifts TX out on each synchronised SCLK fall. After FRAME_W bits → DONE.
  - DONE: any further SCLK rise → overflow flag set (frame invalid).
  - Any state, nCS rise → IDLE.
- Commit on nCS rise: write, exactly FRAME_W bits, no overflow, address < NUM_REGS → update register, `wr_addr`, pulse `wr_strobe`. Out-of-range write: silently dropped, no strobe, no error.
- nCS rise with 0 < count < FRAME_W, or overflow → discard, pulse `frame_err`. nCS rise with count 0 → no pulse.
- Reads never alter the register bank; a short read pulses `frame_err` only.
- `CIPO` = TX MSB when `cipo_oe`, else 0.

## Timing
- Reset values: all registers 0, `CIPO` 0, `cipo_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0, FSM IDLE, sync chains 0 (first detected nCS edge after reset is ignored if nCS already high).
- Edge detect latency: pin edge → internal event SYNC_STAGES+1 clk.
- Write commit: register, `wr_addr`, `wr_strobe` all update SYNC_STAGES+2 clk after the nCS pin rise; `frame_err` same cycle.
- Read: first data bit on CIPO SYNC_STAGES+2 clk after the SCLK rise that sampled the last address bit; later bits same latency after each SCLK fall.
- Legal SCLK: each half period ≥ SYNC_STAGES+3 clk periods.
- Same-cycle nCS-rise and SCLK-rise events: nCS wins; the SCLK edge is not counted.
- `rst_n` low mid-frame: all state cleared next clk edge; partial frame lost, no `frame_err`.

## Structure
- Package `spi_regfile_pkg`: FSM state enum, R/W opcode constants, `FRAME_W` derivation function.
- Sub-module `spi_pin_sync` (parameter SYNC_STAGES): synchroniser plus rise/fall pulses; instanced for SCLK, nCS; COPI uses the data output only.

## Test plan
- Write 0x02 ← 0xA5 (frame 1_0000010_10100101) → reg 2 = 0xA5, `wr_strobe` once, `wr_addr`=2, others 0.
- Read addr 2 after above → CIPO shifts 1010_0101, `cipo_oe` high for 8 bits, no register change.
- Write truncated after 10 bits, then nCS rise → `frame_err` pulse, bank unchanged.
- 17-bit write (one extra SCLK) → `frame_err`, no commit; write to addr 0x7F → no strobe, no error; read 0x7F → 0x00.
- `rst_n` low after 9 bits of a write to reg 4 → all outputs 0, subsequent full frame commits normally.
- Re-run with DATA_W=16, NUM_REGS=8 → write/read reg 7 = 0xBEEF round-trips.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Holds the FSM state encoding, the R/W opcode values and the frame length derivation.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// Pin-side and register-side signals of the SPI register-file peripheral.
// Signal names follow the chip pin naming.
interface spi_regfile_if #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
);
  logic                       SCLK;
  logic                       nCS;
  logic                       COPI;
  logic                       CIPO;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  modport slave (
    input  SCLK, nCS, COPI,
    output CIPO, cipo_oe, regs_flat, wr_strobe, wr_addr, frame_err
  );

  modport master (
    output SCLK, nCS, COPI,
    input  CIPO, cipo_oe, regs_flat, wr_strobe, wr_addr, frame_err
  );
endinterface

// File: rtl/spi_regfile_peripheral_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with registered rise/fall pulses.
// The level output is delayed one extra flop so it lines up with the edge pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target with a parametrised register bank, read-back and commit on nCS rise.
// state   | meaning
// ST_IDLE | nCS high, waiting for a frame
// ST_HDR  | shifting R/W bit and address
// ST_DATA | shifting write data in or read data out
// ST_DONE | full frame seen; any extra SCLK marks overflow
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_regfile_if.slave bus
);
  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
  logic w_cs_rise, w_cs_fall, w_cs_lvl;
  logic w_copi;
  logic [1:0] w_unused_copi_edges;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.SCLK),
    .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.nCS),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.COPI),
    .o_level(w_copi), .o_rise(w_unused_copi_edges[0]), .o_fall(w_unused_copi_edges[1]));

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_hdr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic                r_oe;
  logic                r_strobe;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_err;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_bit;
  logic [ADDR_W:0]     w_hdr_next;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_in_range;
  logic                w_cnt_full;

  assign w_bit      = w_sclk_rise & ~w_cs_lvl;
  assign w_hdr_next = {r_hdr, w_copi};
  assign w_in_range = ({1'b0, r_addr} < (ADDR_W + 1)'(NUM_REGS));
  assign w_cnt_full = (r_cnt == CNT_W'(FRAME_W));

  // Unimplemented addresses read back as zero.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_hdr_next[ADDR_W-1:0] == ADDR_W'(k)) w_rd_data = r_regs[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_rw      <= OP_READ;
      r_hdr     <= '0;
      r_addr    <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_oe      <= 1'b0;
      r_strobe  <= 1'b0;
      r_wr_addr <= '0;
      r_err     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      if (w_cs_rise) begin
        // nCS rise takes priority over an SCLK edge in the same cycle.
        if (r_rw == OP_WRITE && w_cnt_full && !r_ovf) begin
          if (w_in_range) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (r_addr == ADDR_W'(k)) r_regs[k] <= r_rx;
            r_wr_addr <= r_addr;
            r_strobe  <= 1'b1;
          end
        end else if (r_ovf || (r_cnt != '0 && !w_cnt_full)) begin
          r_err <= 1'b1;
        end
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_oe    <= 1'b0;
        r_tx    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_cs_fall) begin
            r_state <= ST_HDR;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_rw    <= OP_READ;
          end
          ST_HDR: if (w_bit) begin
            r_hdr <= w_hdr_next[ADDR_W-1:0];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(ADDR_W)) begin
              r_state <= ST_DATA;
              r_rw    <= w_hdr_next[ADDR_W];
              r_addr  <= w_hdr_next[ADDR_W-1:0];
              if (w_hdr_next[ADDR_W] == OP_READ) begin
                r_tx <= w_rd_data;
                r_oe <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (w_bit) begin
              r_cnt <= r_cnt + 1'b1;
              r_rx  <= DATA_W'({r_rx, w_copi});
              if (r_cnt == CNT_W'(FRAME_W - 1)) r_state <= ST_DONE;
            end else if (w_sclk_fall && r_oe && r_cnt != CNT_W'(ADDR_W + 1)) begin
              // The fall right after the last address bit keeps the MSB on the pin.
              r_tx <= r_tx << 1;
            end
          end
          ST_DONE: begin
            if (w_bit) r_ovf <= 1'b1;
            else if (w_sclk_fall) r_oe <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.CIPO      = r_oe & r_tx[DATA_W-1];
  assign bus.cipo_oe   = r_oe;
  assign bus.wr_strobe = r_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.frame_err = r_err;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: an 8-bit/5-register and a 16-bit/8-register instance.
// Expected writes and read data are queued at stimulus time and compared when the DUT responds.
module tb_spi_regfile_peripheral;
  localparam int HP = 6;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, copi = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1;
  always #5 clk = ~clk;

  spi_regfile_if #(.ADDR_W(7), .DATA_W(8),  .NUM_REGS(5)) bus_a ();
  spi_regfile_if #(.ADDR_W(7), .DATA_W(16), .NUM_REGS(8)) bus_b ();

  assign bus_a.SCLK = sclk;
  assign bus_a.COPI = copi;
  assign bus_a.nCS  = ncs_a;
  assign bus_b.SCLK = sclk;
  assign bus_b.COPI = copi;
  assign bus_b.nCS  = ncs_b;

  spi_regfile_peripheral #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  spi_regfile_peripheral #(.ADDR_W(7), .DATA_W(16), .NUM_REGS(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;
  wr_t wq_a[$], wq_b[$];
  logic [15:0] rq[$];
  logic [7:0]  mdl_a [5];
  logic [15:0] mdl_b [8];
  int strb_a = 0, strb_b = 0, err_a = 0, err_b = 0;
  int exp_strb_a = 0, exp_strb_b = 0, exp_err_a = 0, exp_err_b = 0;
  wr_t e_a, e_b;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.wr_strobe) begin
      strb_a++;
      check_val("a_strobe_expected", 32'(wq_a.size() != 0), 1);
      if (wq_a.size() != 0) begin
        e_a = wq_a.pop_front();
        check_val("a_wr_addr", bus_a.wr_addr, e_a.addr);
        check_val("a_wr_data", bus_a.regs_flat[e_a.addr*8 +: 8], e_a.data);
      end
    end
    if (bus_b.wr_strobe) begin
      strb_b++;
      check_val("b_strobe_expected", 32'(wq_b.size() != 0), 1);
      if (wq_b.size() != 0) begin
        e_b = wq_b.pop_front();
        check_val("b_wr_addr", bus_b.wr_addr, e_b.addr);
        check_val("b_wr_data", bus_b.regs_flat[e_b.addr*16 +: 16], e_b.data);
      end
    end
    if (bus_a.frame_err) err_a++;
    if (bus_b.frame_err) err_b++;
  end

  task automatic spi_xfer(input bit sel, input logic [31:0] bits, input int nbits,
                          input bit end_cs, output logic [31:0] rx, output int oe_cnt);
    rx = '0;
    oe_cnt = 0;
    if (sel) ncs_b = 1'b0; else ncs_a = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (HP) @(negedge clk);
      rx = {rx[30:0], (sel ? bus_b.CIPO : bus_a.CIPO)};
      oe_cnt += int'(sel ? bus_b.cipo_oe : bus_a.cipo_oe);
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
    if (end_cs) begin
      repeat (HP) @(negedge clk);
      ncs_a = 1'b1;
      ncs_b = 1'b1;
    end
  endtask

  task automatic check_bank(input bit sel, input string tag);
    if (sel) begin
      for (int k = 0; k < 8; k++)
        check_val($sformatf("%s_b_reg%0d", tag, k), bus_b.regs_flat[k*16 +: 16], mdl_b[k]);
    end else begin
      for (int k = 0; k < 5; k++)
        check_val($sformatf("%s_a_reg%0d", tag, k), bus_a.regs_flat[k*8 +: 8], mdl_a[k]);
    end
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_strb_a"}, strb_a, exp_strb_a);
    check_val({tag, "_strb_b"}, strb_b, exp_strb_b);
    check_val({tag, "_err_a"}, err_a, exp_err_a);
    check_val({tag, "_err_b"}, err_b, exp_err_b);
  endtask

  task automatic push_write(input bit sel, input logic [6:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    if (sel) begin
      if (addr < 8) begin
        e.data = data;
        wq_b.push_back(e);
        mdl_b[int'(addr)] = data;
        exp_strb_b++;
      end
    end else if (addr < 5) begin
      e.data = {8'h00, data[7:0]};
      wq_a.push_back(e);
      mdl_a[int'(addr)] = data[7:0];
      exp_strb_a++;
    end
  endtask

  task automatic do_write(input bit sel, input logic [6:0] addr, input logic [15:0] data);
    logic [31:0] bits, rx;
    int oe;
    bits = sel ? {8'h00, 1'b1, addr, data} : {16'h0000, 1'b1, addr, data[7:0]};
    push_write(sel, addr, data);
    spi_xfer(sel, bits, sel ? 24 : 16, 1'b1, rx, oe);
    repeat (10) @(negedge clk);
    check_val($sformatf("wr_oe_%0d_%0h", sel, addr), oe, 0);
    check_counts($sformatf("wr_%0d_%0h", sel, addr));
  endtask

  task automatic do_read(input bit sel, input logic [6:0] addr);
    logic [31:0] bits, rx;
    logic [15:0] exp;
    int oe;
    if (sel) rq.push_back((addr < 8) ? mdl_b[int'(addr[2:0])] : 16'h0000);
    else     rq.push_back((addr < 5) ? {8'h00, mdl_a[int'(addr) % 5]} : 16'h0000);
    bits = sel ? {8'h00, 1'b0, addr, 16'h0000} : {16'h0000, 1'b0, addr, 8'h00};
    spi_xfer(sel, bits, sel ? 24 : 16, 1'b1, rx, oe);
    exp = rq.pop_front();
    check_val($sformatf("rd_data_%0d_%0h", sel, addr), sel ? rx[15:0] : {8'h00, rx[7:0]}, exp);
    check_val($sformatf("rd_oe_bits_%0d_%0h", sel, addr), oe, sel ? 16 : 8);
    repeat (10) @(negedge clk);
    check_val($sformatf("rd_oe_end_%0d", sel), sel ? bus_b.cipo_oe : bus_a.cipo_oe, 0);
    check_counts($sformatf("rd_%0d_%0h", sel, addr));
    check_bank(sel, "rd");
  endtask

  initial begin
    logic [31:0] rx;
    int oe;
    logic [15:0] rnd [5];
    for (int k = 0; k < 5; k++) mdl_a[k] = 8'h00;
    for (int k = 0; k < 8; k++) mdl_b[k] = 16'h0000;

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_bank(1'b0, "rst");
    check_bank(1'b1, "rst");
    check_val("rst_cipo", bus_a.CIPO, 0);
    check_val("rst_oe", bus_a.cipo_oe, 0);
    check_val("rst_strobe", bus_a.wr_strobe, 0);
    check_val("rst_wr_addr", bus_a.wr_addr, 0);
    check_counts("rst");

    // Write reg 2 <- 0xA5 and check commit latency from the nCS pin rise.
    push_write(1'b0, 7'd2, 16'h00A5);
    spi_xfer(1'b0, 32'h000082A5, 16, 1'b1, rx, oe);
    repeat (3) @(negedge clk);
    check_val("lat_early_strobe", bus_a.wr_strobe, 0);
    check_val("lat_early_reg2", bus_a.regs_flat[2*8 +: 8], 8'h00);
    @(negedge clk);
    check_val("lat_strobe", bus_a.wr_strobe, 1);
    check_val("lat_wr_addr", bus_a.wr_addr, 7'd2);
    check_val("lat_frame_err", bus_a.frame_err, 0);
    repeat (10) @(negedge clk);
    check_counts("w2");
    check_bank(1'b0, "w2");

    do_read(1'b0, 7'd2);

    // Truncated write: 10 bits of a write to reg 1.
    spi_xfer(1'b0, 32'h000081FF >> 6, 10, 1'b1, rx, oe);
    exp_err_a++;
    repeat (10) @(negedge clk);
    check_counts("trunc");
    check_bank(1'b0, "trunc");

    // One SCLK too many.
    spi_xfer(1'b0, {15'h0000, 16'h813C, 1'b0}, 17, 1'b1, rx, oe);
    exp_err_a++;
    repeat (10) @(negedge clk);
    check_counts("ovf");
    check_bank(1'b0, "ovf");

    do_write(1'b0, 7'h7F, 16'h0055);
    do_write(1'b0, 7'd5, 16'h0066);
    check_bank(1'b0, "oor");
    do_read(1'b0, 7'h7F);
    do_read(1'b0, 7'd5);

    // Reset in the middle of a write to reg 4.
    spi_xfer(1'b0, 32'h0000845A >> 7, 9, 1'b0, rx, oe);
    rst_n = 1'b0;
    ncs_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) mdl_a[k] = 8'h00;
    check_bank(1'b0, "midrst");
    check_val("midrst_cipo", bus_a.CIPO, 0);
    check_val("midrst_oe", bus_a.cipo_oe, 0);
    check_val("midrst_strobe", bus_a.wr_strobe, 0);
    check_val("midrst_wr_addr", bus_a.wr_addr, 0);
    check_val("midrst_err", bus_a.frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_counts("midrst");
    do_write(1'b0, 7'd4, 16'h005A);
    check_bank(1'b0, "postrst");

    for (int k = 0; k < 5; k++) begin
      rnd[k] = 16'($urandom);
      do_write(1'b0, 7'(k), rnd[k]);
    end
    for (int k = 4; k >= 0; k--) do_read(1'b0, 7'(k));

    do_write(1'b1, 7'd7, 16'hBEEF);
    do_read(1'b1, 7'd7);
    do_write(1'b1, 7'd0, 16'h1234);
    do_write(1'b1, 7'd8, 16'hDEAD);
    do_read(1'b1, 7'd0);
    do_read(1'b1, 7'd8);
    check_bank(1'b0, "end");

    check_val("wq_a_empty", wq_a.size(), 0);
    check_val("wq_b_empty", wq_b.size(), 0);
    check_val("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
